ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
Parametrised successor to the single-digit PS/2 receiver. Samples the PS/2 clock/data lines in the system clock domain and validates full 11-bit frames (start, parity, stop, inter-edge timeout). Good bytes are pushed into an internal FIFO, which is drained through a valid/ready handshake. Sits between the keyboard pins and the keypad/display logic, replacing the old digit-only, unbuffered receiver.

Parameters:
SYNC_STAGES, 2, synchroniser flops on ps2_clk_i and ps2_data_i; legal range 2..4
FIFO_DEPTH, 4, bytes buffered; power of 2, at least 2
TIMEOUT_CYCLES, 2000, clk_i cycles allowed between PS/2 falling edges inside a frame before the frame is aborted; at least 4

Ports:
clk_i  in  1  system clock; all logic on the rising edge
rst_i  in  1  asynchronous, active-low reset
ps2_clk_i  in  1  raw PS/2 clock, asynchronous to clk_i
ps2_data_i  in  1  raw PS/2 data, asynchronous to clk_i
data_o  out  8  FIFO head byte; valid only while valid_o=1
valid_o  out  1  FIFO not empty
ready_i  in  1  consumer accepts data_o when valid_o&&ready_i
frame_err_o  out  1  one-cycle pulse on a rejected or aborted frame
overflow_o  out  1  sticky; a good byte was dropped because the FIFO was full
fill_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_i=0, async): FSM to IDLE; FIFO empty; data_o=0, valid_o=0, frame_err_o=0, overflow_o=0, fill_o=0; synchronisers to 1; bit counter and timeout counter to 0.
- Sampling: ps2_clk_i and ps2_data_i each pass through SYNC_STAGES flops. A falling edge is detected as sync_clk_prev=1 && sync_clk=0. Data is sampled from the synchronised data line in the detect cycle.
- FSM:
  - IDLE: on a falling edge with data=0, go to DATA with bitcnt=0. On data=1, stay in IDLE with no error (treated as a glitch).
  - DATA: shift bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the parity bit and go to STOP.
  - STOP: the stop bit must be 1 and the 9 bits (data plus parity) must have odd parity.
    - Both checks pass: push the byte, go to IDLE.
    - Either check fails: pulse frame_err_o, discard the byte, go to IDLE.
- Latency: the push happens in the cycle after the stop-bit edge is detected. valid_o rises in the cycle after the push.
- Timeout: the counter clears on every falling edge and in IDLE, and increments otherwise. In any state other than IDLE, reaching TIMEOUT_CYCLES aborts the frame: pulse frame_err_o, go to IDLE, discard partial data.
- FIFO: circular buffer with a read pointer, a write pointer and a count.
  - data_o shows the head entry combinationally.
  - Pop when valid_o && ready_i.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO full:
  - A push with no simultaneous pop drops the byte and sets overflow_o. overflow_o stays set until reset.
  - A push with a simultaneous pop succeeds; the count is unchanged.
- FIFO empty: ready_i is ignored. No underflow; pointers do not move.
- Simultaneous push and pop at any fill level: both are performed and fill_o is unchanged.
- Reset mid-frame: the partial frame and all FIFO contents are lost immediately.

Optional Feature:
PS2_BREAK_FILTER_EN
- Defined: a good byte 0xF0 is not pushed. It arms a one-shot flag so that the next good byte (the released key's code) is also discarded; the flag then clears. A framing error or timeout also clears the flag. Result: only make codes reach the FIFO.
- Undefined: every good byte, including 0xF0 and the byte after it, is pushed.

Test Plan:
- Reset, then a valid frame for 0x16 (start 0; data LSB-first 0,1,1,0,1,0,0,0; parity 0; stop 1) with ready_i=0 -> valid_o=1, data_o=0x16, fill_o=1, frame_err_o never pulses.
- Same frame with parity bit 1 -> frame_err_o pulses once; valid_o stays 0; fill_o=0.
- Send 3 bits of a frame, then hold ps2_clk_i high for TIMEOUT_CYCLES+5 cycles, then a valid 0x45 frame -> one frame_err_o pulse; FIFO then holds only 0x45.
- ready_i=0, send FIFO_DEPTH+1 valid frames 0x16,0x1E,0x26,0x25,0x2E -> fill_o=4, overflow_o=1; draining with ready_i=1 yields 0x16,0x1E,0x26,0x25; valid_o drops after the 4th pop.
- Frames 0xF0 then 0x16, then 0x1E -> with PS2_BREAK_FILTER_EN only 0x1E is output; without it the output is 0xF0, 0x16, 0x1E in order.
- Pull rst_i low mid-frame with 2 bytes buffered -> all outputs return to reset values immediately; a subsequent valid 0x16 frame is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx_fifo
//  Purpose  : PS/2 keyboard receiver. Synchronises the raw PS/2 clock/data
//             lines, validates 11-bit frames (start, 8 data LSB-first, odd
//             parity, stop, inter-edge timeout) and buffers good bytes in a
//             small FIFO drained through a valid/ready handshake.
//  Ports    : clk_i        system clock (rising edge)
//             rst_i        asynchronous active-low reset
//             ps2_clk_i    raw PS/2 clock (asynchronous)
//             ps2_data_i   raw PS/2 data  (asynchronous)
//             data_o       FIFO head byte (0 while empty)
//             valid_o      FIFO not empty
//             ready_i      consumer accepts data_o when valid_o && ready_i
//             frame_err_o  one-cycle pulse on a rejected or aborted frame
//             overflow_o   sticky: a good byte was dropped (FIFO full)
//             fill_o       current FIFO occupancy
//  Option   : PS2_BREAK_FILTER_EN - when defined, 0xF0 and the byte after
//             it are discarded so only make codes reach the FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            ps2_clk_i,
  input  logic                            ps2_data_i,
  output logic [7:0]                      data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            frame_err_o,
  output logic                            overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] c_tmo  = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] c_full = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // --------------------------------------------------------------------------
  // Synchronisers and falling-edge detect
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_dat;
  logic                   w_fall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data_i};
      r_clk_prev <= w_clk_s;
    end
  end

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat   = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [2:0]      r_bitcnt;
  logic [TW-1:0]   r_tcnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_push;
  logic            r_err;
`ifdef PS2_BREAK_FILTER_EN
  logic            r_brk;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_tcnt   <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_push   <= 1'b0;
      r_err    <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      r_brk    <= 1'b0;
`endif
    end else begin
      r_push <= 1'b0;
      r_err  <= 1'b0;

      if (r_state == S_IDLE || w_fall) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      if (r_state != S_IDLE && !w_fall && r_tcnt == c_tmo) begin
        // Line went quiet mid-frame: abort and drop the partial byte.
        r_state <= S_IDLE;
        r_err   <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
        r_brk   <= 1'b0;
`endif
      end else if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            // A high data bit at an edge is not a start bit; ignore it.
            if (!w_dat) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {w_dat, r_shift[7:1]};
            if (r_bitcnt == 3'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
          S_PARITY: begin
            r_par   <= w_dat;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (w_dat && (^{r_shift, r_par})) begin
`ifdef PS2_BREAK_FILTER_EN
              // 0xF0 arms a one-shot that swallows the released key's code.
              if (r_brk) begin
                r_brk <= 1'b0;
              end else if (r_shift == 8'hF0) begin
                r_brk <= 1'b1;
              end else begin
                r_push <= 1'b1;
              end
`else
              r_push <= 1'b1;
`endif
            end else begin
              r_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              r_brk <= 1'b0;
`endif
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign frame_err_o = r_err;

  // --------------------------------------------------------------------------
  // FIFO. r_shift is stable in IDLE, so it doubles as the write data the
  // cycle after the stop bit.
  // --------------------------------------------------------------------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;

  assign valid_o = (r_cnt != '0);
  assign w_full  = (r_cnt == c_full);
  assign w_pop   = valid_o & ready_i;
  // A full FIFO still accepts a push when the head is leaving this cycle.
  assign w_wr    = r_push & (~w_full | w_pop);

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr] <= r_shift;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (r_push && !w_wr) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign data_o     = valid_o ? r_mem[r_rd] : 8'h00;
  assign overflow_o = r_ovf;
  assign fill_o     = r_cnt;

endmodule
`default_nettype wire
